// File: rtl/int_to_float.sv
// Signed two's-complement integer to float converter, four registered stages.
// Latency 4 enabled cycles; no backpressure, ce=0 freezes every stage including the output.
module int_to_float #(
   parameter int MANTISSA_SIZE        = 23,
   parameter int EXPONENT_SIZE        = 8,
   parameter int INT_SIZE             = 32,
   parameter int EXPONENT_BIAS_OFFSET = 0,
   localparam int FLOAT_SIZE          = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [INT_SIZE-1:0]   in,
   output logic                  out_valid,
   output logic [FLOAT_SIZE-1:0] out
);

   localparam int EW    = EXPONENT_SIZE + 2;
   localparam int LZW   = $clog2(INT_SIZE + 1);
   localparam int BIAS  = (2 ** (EXPONENT_SIZE - 1)) - 1 + EXPONENT_BIAS_OFFSET;
   localparam int LOW_W = INT_SIZE - 2 - MANTISSA_SIZE;
   localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXPONENT_SIZE) - 1);
   // Ties always round away, so the sticky bit never changes the decision.
   localparam logic TIES_AWAY = 1'b1;

   // stage 1: sign / magnitude
   logic                v1, sign1, zero1;
   logic [INT_SIZE-1:0] mag1;
   // stage 2: leading-zero count and exponent
   logic                v2, sign2, zero2;
   logic [INT_SIZE-1:0] mag2;
   logic [LZW-1:0]      lzc2;
   logic signed [EW-1:0] e2;
   // stage 3: normalised mantissa
   logic                v3, sign3, zero3, guard3, sticky3;
   logic [MANTISSA_SIZE-1:0] mant3;
   logic signed [EW-1:0] e3;

   logic [INT_SIZE-1:0]      mag_c;
   logic [LZW-1:0]           lzc_c;
   logic signed [EW-1:0]     e_c;
   logic [INT_SIZE-2:0]      norm_c;
   logic [MANTISSA_SIZE-1:0] mant_c;
   logic                     guard_c, sticky_c, round_up_c;
   logic [MANTISSA_SIZE:0]   mant_r_c;
   logic signed [EW-1:0]     e_r_c;
   logic [FLOAT_SIZE-1:0]    out_c;

   // |INT_MIN| wraps to 2^(INT_SIZE-1), which is the correct unsigned magnitude.
   always_comb begin
      mag_c = in[INT_SIZE-1] ? (~in + INT_SIZE'(1)) : in;
   end

   always_comb begin
      lzc_c = LZW'(INT_SIZE);
      for (int i = 0; i < INT_SIZE; i++) begin
         if (mag1[i]) lzc_c = LZW'(INT_SIZE - 1 - i);
      end
      e_c = EW'(INT_SIZE - 1 + BIAS) - EW'(lzc_c);
   end

   // Hidden bit is dropped by the truncating cast; mantissa starts just below it.
   always_comb begin
      norm_c   = (INT_SIZE-1)'(mag2 << lzc2);
      mant_c   = norm_c[INT_SIZE-2 -: MANTISSA_SIZE];
      guard_c  = norm_c[LOW_W];
      sticky_c = 1'b0;
      for (int i = 0; i < LOW_W; i++) begin
         sticky_c = sticky_c | norm_c[i];
      end
   end

   always_comb begin
      round_up_c = guard3 & (sticky3 | TIES_AWAY);
      mant_r_c   = {1'b0, mant3} + (MANTISSA_SIZE+1)'(round_up_c);
      e_r_c      = e3 + EW'(mant_r_c[MANTISSA_SIZE]);
      out_c      = {sign3, e_r_c[EXPONENT_SIZE-1:0], mant_r_c[MANTISSA_SIZE-1:0]};
      if (zero3) begin
         out_c = '0;
      end else if (e_r_c >= EMAX) begin
         out_c = {sign3, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
      end else if (e_r_c[EW-1] || (e_r_c == '0)) begin
         out_c = {sign3, {(FLOAT_SIZE-1){1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1        <= 1'b0;
         sign1     <= 1'b0;
         zero1     <= 1'b0;
         mag1      <= '0;
         v2        <= 1'b0;
         sign2     <= 1'b0;
         zero2     <= 1'b0;
         mag2      <= '0;
         lzc2      <= '0;
         e2        <= '0;
         v3        <= 1'b0;
         sign3     <= 1'b0;
         zero3     <= 1'b0;
         guard3    <= 1'b0;
         sticky3   <= 1'b0;
         mant3     <= '0;
         e3        <= '0;
         out_valid <= 1'b0;
         out       <= '0;
      end else if (ce) begin
         v1        <= in_valid;
         sign1     <= in[INT_SIZE-1];
         zero1     <= (in == '0);
         mag1      <= mag_c;
         v2        <= v1;
         sign2     <= sign1;
         zero2     <= zero1;
         mag2      <= mag1;
         lzc2      <= lzc_c;
         e2        <= e_c;
         v3        <= v2;
         sign3     <= sign2;
         zero3     <= zero2;
         guard3    <= guard_c;
         sticky3   <= sticky_c;
         mant3     <= mant_c;
         e3        <= e2;
         out_valid <= v3;
         out       <= out_c;
      end
   end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: four instances with different bias offsets share one stream.
module tb_int_to_float;

   localparam int NI = 4;
   localparam int OFFS [NI] = '{0, -1, 200, -130};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] din = '0;
   logic        ov_w  [NI];
   logic [31:0] out_w [NI];

   typedef struct {
      logic [31:0] v;
      int          tag;
      int          orig;
      bit          rt;
   } item_t;

   item_t exp_q [NI][$];

   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   int  en_cnt = 0;
   bit  rst_q = 1'b1;
   bit  ce_q = 1'b0;
   bit  gold_on = 1'b0;
   int  gold_inst = 0;
   logic [31:0] gold_val = '0;
   logic        prev_ov  [NI];
   logic [31:0] prev_out [NI];

   always #5 clk = ~clk;

   int_to_float #(.EXPONENT_BIAS_OFFSET(0)) u_dut0 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in(din),
      .out_valid(ov_w[0]), .out(out_w[0]));
   int_to_float #(.EXPONENT_BIAS_OFFSET(-1)) u_dut1 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in(din),
      .out_valid(ov_w[1]), .out(out_w[1]));
   int_to_float #(.EXPONENT_BIAS_OFFSET(200)) u_dut2 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in(din),
      .out_valid(ov_w[2]), .out(out_w[2]));
   int_to_float #(.EXPONENT_BIAS_OFFSET(-130)) u_dut3 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in(din),
      .out_valid(ov_w[3]), .out(out_w[3]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: value * 2^off rounded to 24 significant bits, ties away from zero.
   function automatic logic [31:0] model(input int v, input int off);
      longint mag, q;
      int     p, e;
      logic   s;
      if (v == 0) return 32'h0;
      s   = (v < 0);
      mag = s ? -longint'(v) : longint'(v);
      p   = 0;
      while ((mag >> (p + 1)) != 0) p++;
      if (p > 23) begin
         q = mag >> (p - 23);
         q = q + ((mag >> (p - 24)) & 64'd1);
      end else begin
         q = mag << (23 - p);
      end
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         p++;
      end
      e = p + 127 + off;
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], q[22:0]};
   endfunction

   // Float back to integer, exact for magnitudes up to 2^24.
   function automatic logic [31:0] f2i(input logic [31:0] f);
      int     ex;
      longint m, r;
      ex = int'(f[30:23]);
      if (ex == 0) return 32'h0;
      m = longint'({1'b1, f[22:0]});
      r = (ex >= 150) ? (m << (ex - 150)) : (m >> (150 - ex));
      if (f[31]) r = -r;
      return r[31:0];
   endfunction

   function automatic int rnd_int();
      int s;
      s = ($urandom_range(0, 1) != 0) ? 1 : -1;
      case ($urandom_range(0, 3))
         0: return int'($urandom);
         1: return int'($urandom_range(0, 1 << 25)) - (1 << 24);
         2: return int'($urandom_range(0, 255)) - 128;
         default: return s * ((1 << 24) + int'($urandom_range(0, 7)));
      endcase
   endfunction

   // Expected results are pushed at the edge where the DUT samples the request.
   always @(posedge clk) begin
      item_t it;
      cyc++;
      rst_q = reset;
      ce_q  = ce;
      if (reset) begin
         for (int k = 0; k < NI; k++) exp_q[k].delete();
      end else if (ce) begin
         en_cnt++;
         if (in_valid) begin
            for (int k = 0; k < NI; k++) begin
               it.v    = (gold_on && gold_inst == k) ? gold_val : model(int'(din), OFFS[k]);
               it.tag  = en_cnt;
               it.orig = int'(din);
               it.rt   = (k == 0) && (int'(din) >= -(1 << 24)) && (int'(din) <= (1 << 24));
               exp_q[k].push_back(it);
            end
         end
      end
   end

   always @(negedge clk) begin
      item_t it;
      for (int k = 0; k < NI; k++) begin
         if (rst_q) begin
            check($sformatf("reset_out_valid[%0d]", k), {31'd0, ov_w[k]}, 32'd0);
            check($sformatf("reset_out[%0d]", k), out_w[k], 32'd0);
         end else if (!ce_q) begin
            check($sformatf("stall_hold_valid[%0d]", k), {31'd0, ov_w[k]}, {31'd0, prev_ov[k]});
            check($sformatf("stall_hold_out[%0d]", k), out_w[k], prev_out[k]);
         end else if (ov_w[k] === 1'b1) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("unexpected_valid[%0d]", k), {31'd0, ov_w[k]}, 32'd0);
            end else begin
               it = exp_q[k].pop_front();
               check($sformatf("out[%0d] in=%h", k, it.orig), out_w[k], it.v);
               check($sformatf("latency[%0d]", k), en_cnt - it.tag, 32'd3);
               if (it.rt) check($sformatf("round_trip in=%h", it.orig), f2i(out_w[k]), it.orig);
            end
         end else if (exp_q[k].size() != 0 && exp_q[k][0].tag + 3 <= en_cnt) begin
            check($sformatf("missing_valid[%0d]", k), {31'd0, ov_w[k]}, 32'd1);
            void'(exp_q[k].pop_front());
         end
         prev_ov[k]  = ov_w[k];
         prev_out[k] = out_w[k];
      end
   end

   function automatic int pending();
      int n = 0;
      for (int k = 0; k < NI; k++) n += exp_q[k].size();
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      ce = 1'b1;
      in_valid = 1'b0;
      while (pending() != 0 && guard < 60) begin
         tick();
         guard++;
      end
      check(name, pending(), 32'd0);
   endtask

   task automatic issue(input int v, input bit g, input int gi, input logic [31:0] gv);
      din       = v;
      in_valid  = 1'b1;
      gold_on   = g;
      gold_inst = gi;
      gold_val  = gv;
      tick();
      in_valid  = 1'b0;
      gold_on   = 1'b0;
   endtask

   task automatic burst(input bit stall, output int cycles);
      int start;
      start = cyc;
      for (int i = 0; i < 8; i++) begin
         if (stall && i == 4) begin
            ce = 1'b0;
            repeat (3) tick();
            ce = 1'b1;
         end
         issue(rnd_int(), 1'b0, 0, 32'h0);
      end
      drain("burst_drain");
      cycles = cyc - start;
   endtask

   typedef struct {
      int          v;
      int          inst;
      logic [31:0] gold;
   } dir_t;

   initial begin
      dir_t dir [10];
      int   c_plain, c_stall;

      dir[0] = '{1, 0, 32'h3F800000};
      dir[1] = '{-1, 0, 32'hBF800000};
      dir[2] = '{0, 0, 32'h00000000};
      dir[3] = '{16777217, 0, 32'h4B800001};
      dir[4] = '{16777219, 0, 32'h4B800002};
      dir[5] = '{32'h7FFFFFFF, 0, 32'h4F000000};
      dir[6] = '{32'h80000000, 0, 32'hCF000000};
      dir[7] = '{3, 1, 32'h3FC00000};
      dir[8] = '{1, 2, 32'h7F800000};
      dir[9] = '{1, 3, 32'h00000000};

      // Reset with ce low must still clear the pipeline.
      reset = 1'b1;
      ce    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      ce    = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) issue(dir[i].v, 1'b1, dir[i].inst, dir[i].gold);
      drain("directed_drain");
      repeat (3) tick();

      burst(1'b0, c_plain);
      burst(1'b1, c_stall);
      check("stall_adds_3_cycles", c_stall - c_plain, 32'd3);

      // Three items in flight, then a one-cycle reset: none may emerge.
      for (int i = 0; i < 3; i++) issue(rnd_int(), 1'b0, 0, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      issue(12345, 1'b1, 0, 32'h4640E400);
      drain("post_reset_drain");

      for (int i = 0; i < 300; i++) begin
         ce       = ($urandom_range(0, 9) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         din      = rnd_int();
         tick();
      end
      drain("random_drain");
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
